// File: rtl/ps2_digit_tx.sv
// PS/2 device-side transmitter: turns an accepted decimal digit into its set-2 make-code frame(s).
// Optional macro PS2_DIGIT_TX_BREAK_EN appends a break sequence (F0h, make code) after each make code.
module ps2_digit_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       err,
    output logic [1:0] dbg_state
);

    // Handshake: a digit is taken on a rising edge where din_valid && din_ready;
    // din_ready is high only in IDLE and inputs are ignored otherwise.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [8:0] HALF       = 9'(CLK_DIV);
    localparam logic [8:0] PERIOD_END = 9'(2 * CLK_DIV - 1);

    function automatic logic [7:0] scancode(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h45;
            4'd1:    return 8'h16;
            4'd2:    return 8'h1E;
            4'd3:    return 8'h26;
            4'd4:    return 8'h25;
            4'd5:    return 8'h2E;
            4'd6:    return 8'h36;
            4'd7:    return 8'h3D;
            4'd8:    return 8'h3E;
            4'd9:    return 8'h46;
            default: return 8'h00;
        endcase
    endfunction

    // Frame bit 0 is the start bit; the register shifts right so bit 0 is always on the line.
    function automatic logic [10:0] make_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    state_t      state, state_n;
    logic [8:0]  cnt, cnt_n;
    logic [3:0]  bit_idx, bit_idx_n;
    logic [10:0] frame, frame_n;
    logic        err_n;
    logic        ps2_clk_n, ps2_data_n;

`ifdef PS2_DIGIT_TX_BREAK_EN
    logic [1:0]  byte_idx, byte_idx_n;
    logic [7:0]  code, code_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            frame    <= '1;
            err      <= 1'b0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
`ifdef PS2_DIGIT_TX_BREAK_EN
            byte_idx <= '0;
            code     <= '0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            frame    <= frame_n;
            err      <= err_n;
            ps2_clk  <= ps2_clk_n;
            ps2_data <= ps2_data_n;
`ifdef PS2_DIGIT_TX_BREAK_EN
            byte_idx <= byte_idx_n;
            code     <= code_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        frame_n   = frame;
        err_n     = 1'b0;
`ifdef PS2_DIGIT_TX_BREAK_EN
        byte_idx_n = byte_idx;
        code_n     = code;
`endif
        case (state)
            IDLE: begin
                if (din_valid) begin
                    if (din <= 4'd9) begin
                        state_n   = SHIFT;
                        cnt_n     = '0;
                        bit_idx_n = '0;
                        frame_n   = make_frame(scancode(din));
`ifdef PS2_DIGIT_TX_BREAK_EN
                        byte_idx_n = '0;
                        code_n     = scancode(din);
`endif
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt == PERIOD_END) begin
                    cnt_n = '0;
                    if (bit_idx == 4'd10) begin
                        state_n = GAP;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                        frame_n   = {1'b1, frame[10:1]};
                    end
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            GAP: begin
                if (cnt == PERIOD_END) begin
                    cnt_n = '0;
`ifdef PS2_DIGIT_TX_BREAK_EN
                    if (byte_idx != 2'd2) begin
                        byte_idx_n = byte_idx + 2'd1;
                        bit_idx_n  = '0;
                        frame_n    = make_frame((byte_idx == 2'd0) ? 8'hF0 : code);
                        state_n    = SHIFT;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line levels are registered from next-state so they never glitch.
        ps2_clk_n  = !((state_n == SHIFT) && (cnt_n >= HALF));
        ps2_data_n = (state_n == SHIFT) ? frame_n[0] : 1'b1;
    end

    assign din_ready = (state == IDLE);
    assign busy      = !din_ready;
    assign dbg_state = state;

endmodule
